putc_uart_tx: RTL

- Downstream consumer of the CPU's putc instruction. Replaces the simulation-only character print with a synthesizable serial output.
- Buffers characters emitted by the CPU in a small FIFO and serializes them as 8N1 UART frames on a single tx pin, LSB first.
- Gives the CPU a ready signal so putc can stall instead of losing characters.

---
 rtl/putc_uart_tx.sv | 87 ++++++++
 1 files changed

// File: rtl/putc_uart_tx.sv
// putc_uart_tx: FIFO-buffered 8N1 UART transmitter for the CPU putc path (optional even parity via PUTC_UART_PARITY_EN)
module putc_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            putc_valid,
  input  logic [7:0]      putc_data,
  output logic            putc_ready,
  output logic            tx,
  output logic            busy,
  output logic [ADDR_W:0] level,
  output logic            overflow
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, nxt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0] bidx, bidx_nxt;
  logic [7:0] char_q;
  logic full, push, pop, tick, tx_nxt;
  assign full = level == (ADDR_W+1)'(FIFO_DEPTH);
  assign putc_ready = !full;
  assign push = putc_valid && putc_ready;
  assign pop = (state == IDLE) && (level != '0);
  assign tick = cnt == CNT_MAX;
  assign busy = (state != IDLE) || (level != '0);
  // next state, bit index, baud counter and the registered value of tx for the coming cycle
  always_comb begin
    nxt = state;
    bidx_nxt = bidx;
    case (state)
      IDLE:   nxt = pop ? START : IDLE;
      START:  nxt = tick ? DATA : START;
      DATA: if (tick) begin
        bidx_nxt = bidx + 3'd1;
`ifdef PUTC_UART_PARITY_EN
        nxt = (bidx == 3'd7) ? PARITY : DATA;
`else
        nxt = (bidx == 3'd7) ? STOP : DATA;
`endif
      end
      PARITY: nxt = tick ? STOP : PARITY;
      STOP:   nxt = tick ? IDLE : STOP;
      default: nxt = IDLE;
    endcase
    cnt_nxt = (state == IDLE || nxt != state || tick) ? '0 : cnt + CW'(1);
    tx_nxt = (nxt == START) ? 1'b0 :
             (nxt == DATA) ? char_q[bidx_nxt] :
             (nxt == PARITY) ? ^char_q : 1'b1;
  end
  // FIFO storage; written only on an accepted push
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= putc_data;
  // FIFO bookkeeping, overflow flag and transmitter state
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      cnt <= '0;
      bidx <= '0;
      char_q <= '0;
      tx <= 1'b1;
      overflow <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= cnt_nxt;
      bidx <= bidx_nxt;
      tx <= tx_nxt;
      if (putc_valid && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + ADDR_W'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
        char_q <= mem[rd_ptr];
      end
      if (push && !pop) level <= level + (ADDR_W+1)'(1);
      else if (pop && !push) level <= level - (ADDR_W+1)'(1);
    end
  end
endmodule
